// File: rtl/wfg_spi_capture.sv
// SPI capture stage: oversamples SCLK/CS_N/SDI, deserializes words into a FIFO,
// exposes control, status and data through a Wishbone slave.
module wfg_spi_capture #(
  parameter int BUSW        = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst,
  input  logic [BUSW-1:0] io_wbs_adr,
  input  logic [BUSW-1:0] io_wbs_datwr,
  output logic [BUSW-1:0] io_wbs_datrd,
  input  logic            io_wbs_we,
  input  logic            io_wbs_stb,
  output logic            io_wbs_ack,
  input  logic            io_wbs_cyc,
  input  logic            spi_sclk_i,
  input  logic            spi_cs_ni,
  input  logic            spi_sdi_i,
  output logic            capture_irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic sclk_s, cs_s, sdi_s;
  logic sclk_q, cs_q;
  logic sample, cs_fall, cs_rise;

  logic       en, cpol, irq_en;
  logic [4:0] wl_m1;
  logic       ovf, short_f;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, level;
  logic        empty, full;

  logic [5:0]  cnt, cnt_n, cnt_inc, wl;
  logic [31:0] shreg, sh_n, sh_nxt, mask;
  logic        push, push_ok, pop, short_set, ovf_set;

  logic        acc, wr, flush_w, kill;
  logic [1:0]  sel;
  logic [31:0] rd32;

  logic unused;
  assign unused = ^{io_wbs_adr[BUSW-1:4], io_wbs_adr[1:0],
                    io_wbs_datwr[BUSW-1:13], io_wbs_datwr[7:4],
                    shreg[31]};

  assign sclk_s  = sync_q[SYNC_STAGES-1][0];
  assign cs_s    = sync_q[SYNC_STAGES-1][1];
  assign sdi_s   = sync_q[SYNC_STAGES-1][2];
  assign sample  = cpol ? (sclk_q & ~sclk_s) : (~sclk_q & sclk_s);
  assign cs_fall = cs_q & ~cs_s;
  assign cs_rise = ~cs_q & cs_s;

  assign acc     = io_wbs_stb & io_wbs_cyc & ~io_wbs_ack;
  assign sel     = io_wbs_adr[3:2];
  assign wr      = acc & io_wbs_we;
  assign flush_w = wr & (sel == 2'd0) & io_wbs_datwr[2];
  assign kill    = flush_w | ~en;

  assign level   = wptr - rptr;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH);
  assign pop     = acc & ~io_wbs_we & (sel == 2'd2) & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  assign wl      = {1'b0, wl_m1} + 6'd1;
  assign mask    = 32'hFFFF_FFFF >> (5'd31 - wl_m1);
  assign cnt_inc = cnt + 6'd1;
  assign sh_nxt  = {shreg[30:0], sdi_s};

  assign capture_irq_o = irq_en & ~empty;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = shreg;
    push      = 1'b0;
    short_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sh_n    = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n   = IDLE;
          short_set = (cnt != '0);
          cnt_n     = '0;
        end else if (sample) begin
          sh_n = sh_nxt;
          if (cnt_inc == wl) begin
            push  = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
    endcase
    // disabling or flushing abandons any word in progress silently
    if (kill) begin
      state_n   = IDLE;
      cnt_n     = '0;
      push      = 1'b0;
      short_set = 1'b0;
    end
  end

  always_comb begin
    rd32 = '0;
    case (sel)
      2'd0: rd32 = {19'b0, wl_m1, 4'b0, irq_en, 1'b0, cpol, en};
      2'd1: rd32 = {16'b0, 8'(level), 4'b0, short_f, ovf, full, empty};
      2'd2: rd32 = empty ? 32'd0 : mem[rptr[AW-1:0]];
      default: rd32 = '0;
    endcase
  end

  always_ff @(posedge io_wbs_clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= sh_nxt & mask;
  end

  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst) begin
      sync_q       <= '0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      en           <= 1'b0;
      cpol         <= 1'b0;
      irq_en       <= 1'b0;
      wl_m1        <= '0;
      ovf          <= 1'b0;
      short_f      <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      io_wbs_ack   <= 1'b0;
      io_wbs_datrd <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {spi_sdi_i, spi_cs_ni, spi_sclk_i}};
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= sh_n;
      io_wbs_ack   <= acc;
      io_wbs_datrd <= acc ? BUSW'(rd32) : '0;
      if (wr && sel == 2'd0) begin
        en     <= io_wbs_datwr[0];
        cpol   <= io_wbs_datwr[1];
        irq_en <= io_wbs_datwr[3];
        wl_m1  <= io_wbs_datwr[12:8];
      end
      // a coinciding set event beats the clearing write
      ovf     <= ovf_set | (ovf & ~(wr && sel == 2'd1 && io_wbs_datwr[2]));
      short_f <= short_set |
                 (short_f & ~(wr && sel == 2'd1 && io_wbs_datwr[3]));
      if (flush_w) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
      end
    end
  end

endmodule
